// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and result buffer depth.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } lu_op_e;

  localparam int LU_DEPTH = 2;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational bitwise operator; operand B is ignored for NOT A and PASS A.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (lu_op_e'(in_op))
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_NAND: result = ~(in_a & in_b);
      OP_NOR:  result = ~(in_a | in_b);
      OP_XNOR: result = ~(in_a ^ in_b);
      OP_NOTA: result = ~in_a;
      OP_PASS: result = in_a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Logic unit with a 2-entry result FIFO and valid/ready handshakes on both sides.
// Define LOGIC_UNIT_PIPE_STATS_EN to add the saturating out_count release counter port.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  ,
  output logic [15:0]      out_count
`endif
);

  localparam logic [1:0] DEPTH_C = 2'(LU_DEPTH);

  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic             w_release;
  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .in_a   (in_a),
    .in_b   (in_b),
    .in_op  (in_op),
    .result (w_result)
  );

  // in_ready depends only on the registered count, so out_ready never reaches it combinationally.
  assign in_ready  = (r_count < DEPTH_C) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_count != 2'd0);
  assign w_release = out_valid && out_ready;
  assign out_data  = out_valid ? r_mem[r_rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wrPtr] <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_release) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_accept, w_release})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [15:0] r_outCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outCount <= 16'd0;
    end else if (w_release && (r_outCount != 16'hFFFF)) begin
      r_outCount <= r_outCount + 16'd1;
    end
  end

  assign out_count = r_outCount;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8); stats checks compile only with LOGIC_UNIT_PIPE_STATS_EN.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [15:0] out_count;
`endif

  int total = 0;
  int bad   = 0;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] opExp [0:7];
    opExp[0] = 8'h0A; opExp[1] = 8'hCF; opExp[2] = 8'hC5; opExp[3] = 8'hF5;
    opExp[4] = 8'h30; opExp[5] = 8'h3A; opExp[6] = 8'h35; opExp[7] = 8'hCA;

    // Reset held two cycles with a beat offered: nothing may be accepted
    rst = 1'b1;
    applyStimulus(1'b1, 8'h55, 8'hAA, 3'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd0);
      checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
      checkOutput("rst_out_data", {8'd0, out_data}, 16'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    #1;
    checkOutput("post_rst_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("post_rst_idle", {15'd0, out_valid}, 16'd0);

    // All eight ops on a=CA b=0F, one result per cycle
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 8'hCA, 8'h0F, 3'(k), 1'b1);
      tick();
      checkOutput($sformatf("op%0d_valid", k), {15'd0, out_valid}, 16'd1);
      checkOutput($sformatf("op%0d_data", k), {8'd0, out_data}, {8'd0, opExp[k]});
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("ops_drained_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("ops_drained_data", {8'd0, out_data}, 16'd0);

    // Backpressure: three XOR beats, only two fit
    applyStimulus(1'b1, 8'h01, 8'hFF, 3'd2, 1'b0);
    tick();
    checkOutput("bp_first_data", {8'd0, out_data}, 16'h00FE);
    checkOutput("bp_first_ready", {15'd0, in_ready}, 16'd1);
    applyStimulus(1'b1, 8'h02, 8'hFF, 3'd2, 1'b0);
    tick();
    checkOutput("bp_full_ready", {15'd0, in_ready}, 16'd0);
    checkOutput("bp_full_data", {8'd0, out_data}, 16'h00FE);
    applyStimulus(1'b1, 8'h03, 8'hFF, 3'd2, 1'b0);
    tick();
    checkOutput("bp_hold_ready", {15'd0, in_ready}, 16'd0);
    checkOutput("bp_hold_valid", {15'd0, out_valid}, 16'd1);
    checkOutput("bp_hold_data", {8'd0, out_data}, 16'h00FE);
    applyStimulus(1'b1, 8'h03, 8'hFF, 3'd2, 1'b1);
    tick();
    checkOutput("bp_drain1_data", {8'd0, out_data}, 16'h00FD);
    checkOutput("bp_drain1_ready", {15'd0, in_ready}, 16'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("bp_drain2_data", {8'd0, out_data}, 16'h00FC);
    tick();
    checkOutput("bp_empty_valid", {15'd0, out_valid}, 16'd0);

    // Streaming PASS beats with both sides always ready
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 8'h00, 3'd7, 1'b1);
      tick();
      checkOutput($sformatf("stream%0d_data", i), {8'd0, out_data}, {8'd0, 8'(8'h40 + i)});
      checkOutput($sformatf("stream%0d_ready", i), {15'd0, in_ready}, 16'd1);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("stream_end_valid", {15'd0, out_valid}, 16'd0);

    // Fill to two, then reset mid-stream: buffered beats must vanish
    applyStimulus(1'b1, 8'h11, 8'h00, 3'd7, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h22, 8'h00, 3'd7, 1'b0);
    tick();
    checkOutput("pre_rst_full", {15'd0, in_ready}, 16'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("midrst_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("midrst_data", {8'd0, out_data}, 16'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h33, 8'h00, 3'd7, 1'b1);
    #1;
    checkOutput("midrst_ready", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("midrst_new_data", {8'd0, out_data}, 16'h0033);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("midrst_no_old", {15'd0, out_valid}, 16'd0);

`ifdef LOGIC_UNIT_PIPE_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stats_cleared", out_count, 16'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(i), 8'h00, 3'd7, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("stats_five", out_count, 16'd5);
    force dut.r_outCount = 16'hFFFF;
    tick();
    release dut.r_outCount;
    applyStimulus(1'b1, 8'h77, 8'h00, 3'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("stats_saturate", out_count, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
